// File: rtl/srt_quotient_converter.sv
// srt_quotient_converter: on-the-fly radix-4 SRT quotient conversion with Q/QM registers and remainder-sign correction.
// Optional SRT_QCONV_STICKY_EN adds rem_zero input and sticky output.
module srt_quotient_converter #(
    parameter int NDIGITS = 13,
    localparam int QW = 2 * NDIGITS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          digit_valid,
    output logic          digit_ready,
    input  logic [2:0]    digit,
    input  logic          rem_neg,
    output logic          quo_valid,
    input  logic          quo_ready,
    output logic [QW-1:0] quotient,
    output logic          busy,
`ifdef SRT_QCONV_STICKY_EN
    input  logic          rem_zero,
    output logic          sticky,
`endif
    output logic          digit_err
);
    localparam int CW = $clog2(NDIGITS + 1);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t state;
    logic [QW-1:0] q_r, qm_r, dx, q_nxt, qm_nxt;
    logic [CW-1:0] count;
    logic take, last;
    // dx is the sign-extended digit; QM absorbs the borrow for non-positive digits
    always_comb begin
        dx = {{(QW-3){digit[2]}}, digit};
        q_nxt = digit[2] ? (qm_r << 2) + dx + QW'(4) : (q_r << 2) + dx;
        qm_nxt = (!digit[2] && digit != 3'd0) ? (q_r << 2) + dx - QW'(1) : (qm_r << 2) + dx + QW'(3);
        take = digit_valid && digit_ready;
        last = count == CW'(NDIGITS - 1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            q_r <= '0;
            qm_r <= '1;
            count <= '0;
            digit_ready <= 1'b0;
            quo_valid <= 1'b0;
            quotient <= '0;
            busy <= 1'b0;
            digit_err <= 1'b0;
`ifdef SRT_QCONV_STICKY_EN
            sticky <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    q_r <= '0;
                    qm_r <= '1;
                    count <= '0;
                    digit_err <= 1'b0;
                    digit_ready <= 1'b1;
                    busy <= 1'b1;
                    state <= ACCUM;
                end
                ACCUM: if (take) begin
                    q_r <= q_nxt;
                    qm_r <= qm_nxt;
                    count <= count + CW'(1);
                    if (digit == 3'b100) digit_err <= 1'b1;
                    if (last) begin
                        quotient <= rem_neg ? qm_nxt : q_nxt;
`ifdef SRT_QCONV_STICKY_EN
                        sticky <= ~rem_zero;
`endif
                        quo_valid <= 1'b1;
                        digit_ready <= 1'b0;
                        state <= HOLD;
                    end
                end
                HOLD: if (quo_ready) begin
                    quo_valid <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_srt_quotient_converter.sv
// tb_srt_quotient_converter: randomized check of the quotient converter against an arithmetic digit-sum model.
module tb_srt_quotient_converter;
    localparam int N = 13;
    localparam int QW = 2 * N;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;
    logic start = 0, digit_valid = 0, rem_neg = 0, quo_ready = 0;
    logic [2:0] digit = 0;
    logic digit_ready, quo_valid, busy, digit_err;
    logic [QW-1:0] quotient;
    logic s2_start = 0, s2_dv = 0, s2_rn = 0, s2_qr = 0;
    logic [2:0] s2_digit = 0;
    logic s2_dr, s2_qv, s2_busy, s2_err;
    logic [3:0] s2_q;
`ifdef SRT_QCONV_STICKY_EN
    logic rem_zero = 0, sticky, s2_rz = 0, s2_st;
`endif
    int n_vec = 0, n_err = 0;
    logic [2:0] dig [N];

    srt_quotient_converter #(.NDIGITS(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .digit_valid(digit_valid),
        .digit_ready(digit_ready), .digit(digit), .rem_neg(rem_neg),
        .quo_valid(quo_valid), .quo_ready(quo_ready), .quotient(quotient),
        .busy(busy),
`ifdef SRT_QCONV_STICKY_EN
        .rem_zero(rem_zero), .sticky(sticky),
`endif
        .digit_err(digit_err)
    );

    srt_quotient_converter #(.NDIGITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(s2_start), .digit_valid(s2_dv),
        .digit_ready(s2_dr), .digit(s2_digit), .rem_neg(s2_rn),
        .quo_valid(s2_qv), .quo_ready(s2_qr), .quotient(s2_q),
        .busy(s2_busy),
`ifdef SRT_QCONV_STICKY_EN
        .rem_zero(s2_rz), .sticky(s2_st),
`endif
        .digit_err(s2_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [QW-1:0] model(input bit rn);
        longint v;
        v = 0;
        for (int i = 0; i < N; i++) v = v * 4 + longint'(int'($signed(dig[i])));
        v = v - longint'(rn);
        return v[QW-1:0];
    endfunction

    task automatic conv(input bit rn, input bit gaps, input int bp);
        logic [QW-1:0] exp;
        bit bad, acc;
        int i, guard;
        exp = model(rn);
        bad = 0;
        for (int k = 0; k < N; k++) if (dig[k] == 3'b100) bad = 1;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("busy_accum", busy, 1);
        i = 0;
        guard = 0;
        while (i < N && guard < 200) begin
            digit_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            digit = dig[i];
            rem_neg = (i == N - 1) ? rn : 1'($urandom_range(0, 1));
            acc = digit_valid && digit_ready;
            @(negedge clk);
            if (acc) i++;
            guard++;
        end
        digit_valid = 0;
        if (guard >= 200) chk("digit_timeout", 0, 1);
        chk("quo_valid_lat", quo_valid, 1);
        chk("quotient", quotient, exp);
        chk("ready_hold", digit_ready, 0);
        chk("digit_err", digit_err, bad);
        repeat (bp) begin
            start = 1'($urandom_range(0, 1));
            digit_valid = 1;
            digit = 3'($urandom);
            @(negedge clk);
            chk("hold_quotient", quotient, exp);
            chk("hold_valid", {quo_valid, digit_ready, busy}, 3'b101);
        end
        digit_valid = 0;
        start = 1;
        quo_ready = 1;
        @(negedge clk);
        start = 0;
        quo_ready = 0;
        chk("release", {quo_valid, busy, digit_ready}, 3'b000);
        @(negedge clk);
        chk("idle_keep", {busy, quotient}, {1'b0, exp});
    endtask

    task automatic conv2(input logic [2:0] d0, input logic [2:0] d1, input bit rn, input logic [3:0] exp);
        @(negedge clk);
        s2_start = 1;
        @(negedge clk);
        s2_start = 0;
        s2_dv = 1;
        s2_digit = d0;
        @(negedge clk);
        s2_digit = d1;
        s2_rn = rn;
        @(negedge clk);
        s2_dv = 0;
        chk("n2_valid", s2_qv, 1);
        chk("n2_quotient", s2_q, exp);
        s2_qr = 1;
        @(negedge clk);
        s2_qr = 0;
        chk("n2_release", s2_qv, 0);
    endtask

    initial begin
        #12;
        chk("rst_outputs", {digit_ready, quo_valid, busy, digit_err}, 4'b0000);
        chk("rst_quotient", quotient, 0);
        @(negedge clk);
        rst_n = 1;
        conv2(3'd1, 3'b111, 0, 4'd3);
        conv2(3'd1, 3'b111, 1, 4'd2);
        for (int k = 0; k < N; k++) dig[k] = 3'd3;
        conv(0, 0, 0);
        chk("all_plus3", quotient, 26'h3FFFFFF);
        for (int k = 0; k < N; k++) dig[k] = 3'd0;
        dig[0] = 3'b111;
        conv(0, 0, 5);
        chk("neg_pow", quotient, 26'h3000000);
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < N; k++)
                dig[k] = ($urandom_range(0, 15) == 0) ? 3'b100 : 3'($urandom_range(0, 6) + 5);
            conv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
        end
        dig[2] = 3'b100;
        conv(0, 0, 1);
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        digit_valid = 1;
        digit = 3'b100;
        repeat (6) @(negedge clk);
        digit_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("abort_outputs", {digit_ready, quo_valid, busy, digit_err}, 4'b0000);
        chk("abort_quotient", quotient, 0);
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < N; k++) dig[k] = 3'($urandom_range(0, 6) + 5);
        conv(1, 1, 2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=0 exp=1");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/srt_quotient_converter.md
Name: srt_quotient_converter

Overview:
- Consumer end of the SRT radix-4 digit-selection path. Accepts one signed quotient digit per iteration from the divider datapath.
- Converts the digits on the fly into a non-redundant two's-complement quotient, keeping Q and QM = Q-1 registers. No carry-propagate add is needed at the end.
- Applies the final negative-remainder correction, then presents the quotient through a valid/ready output handshake.

Parameters:
- NDIGITS, 13, number of radix-4 digits per division (quotient width 2*NDIGITS = 26 by default).
- QW, 2*NDIGITS, quotient register width; derived, must not be overridden.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin new conversion; honoured only in IDLE.
- digit_valid  input  1  digit present.
- digit_ready  output  1  converter accepts digit this cycle.
- digit  input  3  signed two's-complement quotient digit, legal range -3..+3.
- rem_neg  input  1  sign of final partial remainder; sampled only with the last digit.
- quo_valid  output  1  quotient available.
- quo_ready  input  1  downstream accepts quotient.
- quotient  output  QW  converted quotient, two's complement.
- busy  output  1  high in ACCUM and HOLD.
- digit_err  output  1  sticky; set when digit = -4 (3'b100) is accepted.

Behaviour:
- Reset (async, rst_n low): state=IDLE, Q=0, QM=all ones, count=0. Outputs: digit_ready=0, quo_valid=0, quotient=0, busy=0, digit_err=0.
- FSM states:
  - IDLE: digit_ready=0. On start, load Q=0, QM={QW{1}}, count=0, clear digit_err, go to ACCUM.
  - ACCUM: digit_ready=1. A transfer occurs when digit_valid&&digit_ready. Per accepted digit q:
    - Q' = (q>=0) ? 4Q+q : 4QM+(4+q)
    - QM' = (q>0) ? 4Q+(q-1) : 4QM+(3+q)
    - Shifts are mod 2^QW (upper bits discarded). count increments.
    - On acceptance of digit number NDIGITS (count==NDIGITS-1): sample rem_neg, set quotient = rem_neg ? QM' : Q', assert quo_valid next cycle, go to HOLD.
  - HOLD: digit_ready=0, quo_valid=1, quotient stable. On quo_ready, deassert quo_valid next cycle and go to IDLE.
- Latency: quotient valid 1 cycle after the last digit is accepted. Throughput is 1 digit/cycle when digit_valid is held high.
- Simultaneous quo_ready and start in HOLD: the quotient is consumed and start is ignored. start is only honoured in IDLE.
- start during ACCUM or HOLD: ignored; no restart.
- Illegal digit -4: treated arithmetically as -4 (Q'=4QM+0, QM'=4QM-1), and digit_err is set. The conversion completes normally.
- digit_valid while not in ACCUM: ignored, no state change.
- Reset mid-operation: abort immediately to reset values. A partially built quotient is never emitted.
- quotient holds its last value in IDLE until the next completion.

Optional Feature:
- Macro: SRT_QCONV_STICKY_EN.
- When defined, add ports rem_zero (input, 1, final remainder is zero, sampled with the last digit, same as rem_neg) and sticky (output, 1).
  - sticky = ~rem_zero, registered alongside quotient.
  - Valid while quo_valid; reset 0.
- When undefined, neither port exists and behaviour is otherwise identical.

Test Plan:
- NDIGITS=2, digits +1,-1, rem_neg=0 -> quotient=3 one cycle after the second digit; QM internally =2.
- Same digits with rem_neg=1 -> quotient=2.
- NDIGITS=13, thirteen +3 digits back-to-back, rem_neg=0 -> quotient=26'h3FFFFFF; completes 14 cycles after the first digit_valid.
- NDIGITS=13, first digit -1, then twelve 0s, rem_neg=0 -> quotient=26'h3000000 (-4^12 mod 2^26).
- Output backpressure: hold quo_ready=0 for 5 cycles; pulse start and drive digit_valid meanwhile -> quotient stable, digit_ready=0, no restart. Then quo_ready=1 -> quo_valid drops and state returns to IDLE.
- Assert rst_n=0 after 6 of 13 digits -> all outputs at reset values immediately. A new start then yields a correct quotient with no residue from the aborted run; a -4 digit sets digit_err and start clears it.
